lbdr_route_ctrl: RTL
====================

LBDR_ROUTE_CTRL -- requirements
Module: lbdr_route_ctrl

Interface
REQ-001 SHALL have parameter X_W, default 2, x-coordinate width.
REQ-002 SHALL have parameter Y_W, default 2, y-coordinate width; address A_W = X_W+Y_W, y in upper bits.
REQ-003 SHALL have parameter ADAPTIVE, default 0; 0 = fixed priority N>E>W>S, 1 = alternate between candidates.
REQ-004 SHALL have parameters RXY_INIT (default 8'd60), CX_INIT (default 4'hF) and CUR_INIT (default 5), giving the reset config values.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  config write strobe.
REQ-008 cfg_rxy  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, bit0 = Rne.
REQ-009 cfg_cx  in  4  connectivity {Cs,Cw,Ce,Cn}, bit0 = Cn.
REQ-010 cfg_cur  in  A_W  local router address.
REQ-011 empty  in  1  input FIFO empty.
REQ-012 flit_id  in  3  head-flit type, one-hot: 001 header, 010 payload, 100 tail.
REQ-013 dst_addr  in  A_W  destination address of the head flit.
REQ-014 grant  in  1  downstream accepts a flit this cycle.
REQ-015 read_en  out  1  pops the FIFO; combinational.
REQ-016 Nport, Eport, Wport, Sport, Lport  out  1 each  registered port select, one-hot or all zero.
REQ-017 busy  out  1  high in ACTIVE.
REQ-018 route_err  out  1  registered one-cycle error pulse.

Function
REQ-019 SHALL compute N1 = y_dst<y_cur, S1 = y_cur<y_dst, E1 = x_cur<x_dst, W1 = x_dst<x_cur, all unsigned.
REQ-020 SHALL form the candidate set with the LBDR equations: N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw)&Cn, and the same pattern for E, W and S; L = no direction bit set.
REQ-021 SHALL reduce the candidates to exactly one port: ADAPTIVE=0 uses priority N>E>W>S; ADAPTIVE=1 with two candidates picks the first by priority when toggle=0 and the second when toggle=1.
REQ-022 SHALL invert toggle on every header routed with two candidates.
REQ-023 SHALL implement states IDLE and ACTIVE.
REQ-024 In IDLE, with ~empty and a header flit at the head, SHALL register the selected port and enter ACTIVE next cycle; read_en SHALL be 0 in that cycle.
REQ-025 In IDLE, with a header flit whose selected set is empty and which is not local, SHALL pulse route_err, assert read_en for one cycle to drop the header, and stay IDLE.
REQ-026 In IDLE, with ~empty and a payload or tail flit at the head, SHALL pulse route_err, drop the flit via read_en, and stay IDLE.
REQ-027 In ACTIVE, read_en SHALL be ~empty & grant, except when REQ-029 applies.
REQ-028 In ACTIVE, when a tail flit is popped, SHALL clear the ports and return to IDLE next cycle.
REQ-029 In ACTIVE, when a header flit is at the head after the packet header has already been popped, SHALL pulse route_err, keep read_en 0, clear the ports and go to IDLE so that header is re-routed.
REQ-030 Port outputs SHALL stay constant for the whole of ACTIVE.
REQ-031 Latency SHALL be 1 cycle from a header at the FIFO head to a valid port; the header pops no earlier than that next cycle.
REQ-032 cfg_we SHALL update Rxy, Cx and cur_addr next cycle in IDLE only; in ACTIVE it SHALL be ignored.
REQ-033 If cfg_we and a header arrive in the same IDLE cycle, routing SHALL use the old config.
REQ-034 Invalid flit_id values (not one-hot) SHALL be treated as payload.

Reset
REQ-035 rst SHALL set state IDLE, all ports 0, route_err 0, busy 0, toggle 0, Rxy=RXY_INIT, Cx=CX_INIT, cur_addr=CUR_INIT; rst has priority over all inputs.
REQ-036 rst mid-packet SHALL abandon the packet, with no read_en during rst.

Verification
REQ-037 After reset defaults (cur=5), header with dst=4'hF -> next cycle Eport=1, other ports 0, busy=1.
REQ-038 Header with dst=5 -> Lport=1; payload then tail popped with grant=1 -> ports 0 and IDLE the cycle after the tail pops.
REQ-039 cfg_cx=4'b1110 written, then header with dst=1 -> route_err pulse, header dropped, ports stay 0.
REQ-040 cfg_rxy=8'h05, ADAPTIVE=1, two packets with dst=3 -> first Nport=1, second Eport=1; ADAPTIVE=0 -> Nport both times.
REQ-041 Header popped, then a second header at the head before any tail -> route_err pulse, read_en 0, ports cleared, the header re-routed the following cycle.
REQ-042 In ACTIVE, grant=0 for 3 cycles -> read_en 0 and ports held; rst mid-packet -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lbdr_route_ctrl.sv
// LBDR routing controller for one router input port: turns the head flit's
// destination into one output-port select and gates FIFO pops for the packet.
module lbdr_route_ctrl #(
  parameter int          X_W      = 2,
  parameter int          Y_W      = 2,
  parameter int          ADAPTIVE = 0,
  parameter logic [7:0]  RXY_INIT = 8'd60,
  parameter logic [3:0]  CX_INIT  = 4'hF,
  parameter int unsigned CUR_INIT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_rxy,
  input  logic [3:0]           cfg_cx,
  input  logic [X_W+Y_W-1:0]   cfg_cur,
  input  logic                 empty,
  input  logic [2:0]           flit_id,
  input  logic [X_W+Y_W-1:0]   dst_addr,
  input  logic                 grant,
  output logic                 read_en,
  output logic                 Nport,
  output logic                 Eport,
  output logic                 Wport,
  output logic                 Sport,
  output logic                 Lport,
  output logic                 busy,
  output logic                 route_err
);

  localparam int             A_W        = X_W + Y_W;
  localparam logic [31:0]    CUR_INIT_W = 32'(CUR_INIT);
  localparam logic [A_W-1:0] CUR_RST    = CUR_INIT_W[A_W-1:0];

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [4:0]     port_q, port_d;
  logic           hdr_done_q, hdr_done_d;
  logic           toggle_q, toggle_d;
  logic           err_q, err_d;
  logic [7:0]     rxy_q, rxy_d;
  logic [3:0]     cx_q, cx_d;
  logic [A_W-1:0] cur_q, cur_d;

  logic [X_W-1:0] x_cur, x_dst;
  logic [Y_W-1:0] y_cur, y_dst;
  logic           n1, s1, e1, w1;
  logic [3:0]     cand, first, pick;
  logic           two, local_hit, route_ok, is_hdr, is_tail;
  logic [4:0]     sel;

  assign x_cur = cur_q[X_W-1:0];
  assign y_cur = cur_q[A_W-1:X_W];
  assign x_dst = dst_addr[X_W-1:0];
  assign y_dst = dst_addr[A_W-1:X_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  // Candidate vector bit order {S,W,E,N} doubles as the N>E>W>S priority order.
  assign cand[0] = (n1 & ~e1 & ~w1 | n1 & e1 & rxy_q[0] | n1 & w1 & rxy_q[1]) & cx_q[0];
  assign cand[1] = (e1 & ~n1 & ~s1 | e1 & n1 & rxy_q[2] | e1 & s1 & rxy_q[3]) & cx_q[1];
  assign cand[2] = (w1 & ~n1 & ~s1 | w1 & n1 & rxy_q[4] | w1 & s1 & rxy_q[5]) & cx_q[2];
  assign cand[3] = (s1 & ~e1 & ~w1 | s1 & e1 & rxy_q[6] | s1 & w1 & rxy_q[7]) & cx_q[3];

  assign first     = cand & (~cand + 4'd1);
  assign two       = |(cand & (cand - 4'd1));
  assign pick      = ((ADAPTIVE != 0) && two && toggle_q) ? (cand & ~first) : first;
  assign local_hit = ~(n1 | s1 | e1 | w1);
  assign sel       = {local_hit, pick};
  assign route_ok  = local_hit | (|cand);

  // Anything that is not a clean header or tail one-hot code counts as payload.
  assign is_hdr  = (flit_id == 3'b001);
  assign is_tail = (flit_id == 3'b100);

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    hdr_done_d = hdr_done_q;
    toggle_d   = toggle_q;
    err_d      = 1'b0;
    rxy_d      = rxy_q;
    cx_d       = cx_q;
    cur_d      = cur_q;
    read_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          rxy_d = cfg_rxy;
          cx_d  = cfg_cx;
          cur_d = cfg_cur;
        end
        if (!empty) begin
          if (is_hdr && route_ok) begin
            port_d     = sel;
            state_d    = ACTIVE;
            hdr_done_d = 1'b0;
            if (two) toggle_d = ~toggle_q;
          end else begin
            err_d   = 1'b1;
            read_en = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // A second header before the tail means the packet was truncated;
        // leave it in the FIFO so IDLE routes it afresh.
        if (!empty && is_hdr && hdr_done_q) begin
          err_d   = 1'b1;
          port_d  = 5'd0;
          state_d = IDLE;
        end else if (!empty && grant) begin
          read_en = 1'b1;
          if (is_hdr) hdr_done_d = 1'b1;
          if (is_tail) begin
            port_d  = 5'd0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) read_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= 5'd0;
      hdr_done_q <= 1'b0;
      toggle_q   <= 1'b0;
      err_q      <= 1'b0;
      rxy_q      <= RXY_INIT;
      cx_q       <= CX_INIT;
      cur_q      <= CUR_RST;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      hdr_done_q <= hdr_done_d;
      toggle_q   <= toggle_d;
      err_q      <= err_d;
      rxy_q      <= rxy_d;
      cx_q       <= cx_d;
      cur_q      <= cur_d;
    end
  end

  assign {Lport, Sport, Wport, Eport, Nport} = port_q;
  assign busy      = (state_q == ACTIVE);
  assign route_err = err_q;

endmodule
